sfifo_watermark: RTL
====================

// Module: sfifo_watermark
// PURPOSE
//  Synchronous single-clock data FIFO with dual-watermark status. Registered
//  high/low watermark flags, a hysteresis interrupt, and sticky
//  overflow/underflow error flags. Used between bus bridges and streaming
//  cores so software or DMA logic is signalled once per fill/drain excursion.
// PARAMETERS
//  BW             8     data width, bits
//  LGFLEN         4     log2 of FIFO depth; FLEN = 1<<LGFLEN entries
//  OPT_ASYNC_READ 1     1: o_data combinational from head; 0: registered, 1-cycle latency
// PORTS
//  i_clk        in   1         clock; all logic on posedge
//  i_reset      in   1         synchronous, active-high reset
//  i_wr         in   1         write request
//  i_data       in   BW        write data
//  o_full       out  1         fill == FLEN
//  o_fill       out  LGFLEN+1  current entry count, registered
//  i_rd         in   1         read request
//  o_data       out  BW        head data (see OPT_ASYNC_READ)
//  o_empty      out  1         fill == 0
//  i_hi_thresh  in   LGFLEN+1  high watermark
//  i_lo_thresh  in   LGFLEN+1  low watermark
//  o_hi         out  1         registered: fill >= hi threshold
//  o_lo         out  1         registered: fill <= lo threshold
//  o_int        out  1         hysteresis interrupt level
//  i_clr_err    in   1         clears sticky error flags
//  o_overflow   out  1         sticky: write attempted while full
//  o_underflow  out  1         sticky: read attempted while empty
// BEHAVIOUR
//  - Reset: pointers/fill=0, o_empty=1, o_full=0, o_hi=0, o_lo=1, o_int=0,
//    o_overflow=0, o_underflow=0; o_data=0 when OPT_ASYNC_READ=0.
//  - w_wr = i_wr && !o_full; w_rd = i_rd && !o_empty. On full, write refused
//    even with a simultaneous read; on empty, read refused even with a write.
//  - Both w_wr and w_rd: fill unchanged, both pointers advance.
//  - Pointers LGFLEN bits, wrap modulo FLEN; fill is LGFLEN+1 bits, 0..FLEN.
//  - nfill = next fill: fill+1 (write only), fill-1 (read only), else fill.
//    Compute in LGFLEN+1 bits with no overflow.
//  - o_hi <= (nfill >= i_hi_thresh); o_lo <= (nfill <= i_lo_thresh).
//    Unsigned compare against the current-cycle thresholds.
//    Invariant after first non-reset clock:
//    o_hi == (o_fill >= $past(i_hi_thresh)).
//  - Thresholds > FLEN: o_hi never asserts. i_lo_thresh >= FLEN: o_lo always 1.
//  - o_int: set when nfill >= i_hi_thresh; else cleared when nfill <= i_lo_thresh;
//    else holds. Set wins when both are true (hi <= lo misconfiguration).
//  - o_overflow set on i_wr && o_full; o_underflow set on i_rd && o_empty.
//    i_clr_err clears both the next cycle; a new event in the same cycle wins.
//  - OPT_ASYNC_READ=1: o_data = mem[rd_ptr] combinationally.
//    OPT_ASYNC_READ=0: o_data <= mem[rd_ptr] on w_rd; holds otherwise.
//  - Memory written at wr_ptr on w_wr only; contents are not reset.
//  - Reset mid-operation discards all data; status returns to reset values.
// TESTING (BW=8, LGFLEN=4, hi=12, lo=4 unless noted)
//  - Write 0x00..0x0F, no reads -> o_full=1 at fill 16; o_hi rises the cycle
//    fill hits 12; o_int=1; 17th write sets o_overflow, fill stays 16.
//  - Drain 16 words -> data 0x00..0x0F in order; o_int stays 1 down to fill 5;
//    clears when fill reaches 4; o_empty=1 at end.
//  - Fill 10, simultaneous rd+wr for 20 cycles (pointers wrap) -> fill stays 10,
//    FIFO order preserved, o_hi=0, o_int holds its prior value.
//  - Full FIFO, rd+wr same cycle -> write refused, fill=15, o_overflow=1.
//    Empty FIFO, rd+wr -> read refused, fill=1, o_underflow=1.
//  - o_overflow=1, then i_clr_err with no event -> 0 next cycle.
//    i_clr_err together with a write while full -> stays 1.
//  - Reset asserted at fill 9, o_int=1 -> next cycle fill=0, o_empty=1,
//    o_lo=1, o_int=0; hi=20 -> o_hi never asserts on a full FIFO.

Source files
------------

// File: rtl/sfifo_watermark.sv
// Single-clock data FIFO with registered high/low watermark flags, a hysteresis
// interrupt level and sticky overflow/underflow error flags.
module sfifo_watermark #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter int OPT_ASYNC_READ = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic [LGFLEN:0]   o_fill,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  input  logic [LGFLEN:0]   i_hi_thresh,
  input  logic [LGFLEN:0]   i_lo_thresh,
  output logic              o_hi,
  output logic              o_lo,
  output logic              o_int,
  input  logic              i_clr_err,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [LGFLEN:0] FLEN = {1'b1, {LGFLEN{1'b0}}};

  logic [BW-1:0]     mem_q [0:(1<<LGFLEN)-1];
  logic [LGFLEN-1:0] wr_ptr_q, rd_ptr_q;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              full_q, empty_q;
  logic              hi_q, lo_q, int_q, int_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              w_wr, w_rd;
  logic              nhi, nlo;

  assign w_wr = i_wr && !full_q;
  assign w_rd = i_rd && !empty_q;

  // Watermarks and the interrupt are evaluated on the next fill so the
  // registered flags line up with the registered fill count.
  always_comb begin
    fill_d = fill_q;
    unique case ({w_wr, w_rd})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    nhi = (fill_d >= i_hi_thresh);
    nlo = (fill_d <= i_lo_thresh);
    int_d = int_q;
    if (nhi)      int_d = 1'b1;
    else if (nlo) int_d = 1'b0;
    ovf_d = ovf_q;
    if (i_wr && full_q) ovf_d = 1'b1;
    else if (i_clr_err) ovf_d = 1'b0;
    unf_d = unf_q;
    if (i_rd && empty_q) unf_d = 1'b1;
    else if (i_clr_err)  unf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      hi_q     <= 1'b0;
      lo_q     <= 1'b1;
      int_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q  <= fill_d;
      full_q  <= (fill_d == FLEN);
      empty_q <= (fill_d == '0);
      hi_q    <= nhi;
      lo_q    <= nlo;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= i_data;
  end

  generate
    if (OPT_ASYNC_READ != 0) begin : g_async_read
      assign o_data = mem_q[rd_ptr_q];
    end else begin : g_sync_read
      logic [BW-1:0] data_q;
      always_ff @(posedge i_clk) begin
        if (i_reset)   data_q <= '0;
        else if (w_rd) data_q <= mem_q[rd_ptr_q];
      end
      assign o_data = data_q;
    end
  endgenerate

  assign o_full      = full_q;
  assign o_fill      = fill_q;
  assign o_empty     = empty_q;
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;
  assign o_int       = int_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule
